conv_z_streamer: RTL and testbench
==================================

# conv_z_streamer

Downstream readout stage of the 8x32 convolution coprocessor. When the convolution FSM reports completion, this block reads the result words from the Z result memory in address order. It streams them to the host over a valid/ready interface, with `last` marking the final word. A 2-entry output buffer absorbs the memory's 1-cycle read latency, so the block sustains one word per cycle under no backpressure and never drops or duplicates a word under backpressure.

## Interface
Parameters:
- DATA_W, 32, width of one Z result word
- ADDR_W, 6, Z memory address width; at most 2**ADDR_W words per stream

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle start pulse, driven from the convolution FSM done indication
- len_i  in  ADDR_W+1  number of words to stream; sampled only on an accepted start
- rd_en_o  out  1  Z memory read enable
- rd_addr_o  out  ADDR_W  Z memory read address
- rd_data_i  in  DATA_W  Z memory read data; valid the cycle after rd_en_o
- m_data_o  out  DATA_W  stream data
- m_valid_o  out  1  stream valid
- m_ready_i  in  1  stream ready
- m_last_o  out  1  high with the final word of a stream
- busy_o  out  1  high while a stream is in progress
- done_o  out  1  one-cycle pulse when a stream completes

## Operation
**States:** IDLE, READ, DRAIN, DONE.
- **IDLE:**
  - start_i=1 latches len_i and clears the read-address and sent counters.
  - If latched len=0, go to DONE; otherwise go to READ.
- **READ:** issues reads at addresses 0,1,2,… When the read at address len-1 is issued, go to DRAIN.
- **DRAIN:** no further reads. When the final word handshakes (m_valid_o & m_ready_i & m_last_o), go to DONE.
- **DONE:** done_o=1 for one cycle, then go to IDLE unconditionally.

**Length clamping:** len_i > 2**ADDR_W is clamped to 2**ADDR_W. The read address never wraps; the last address is 2**ADDR_W-1.

**Read issue rule:**
- rd_en_o=1 in READ only when (fifo_count + inflight − pop) < 2.
  - pop = m_valid_o & m_ready_i.
  - inflight = rd_en_o registered one cycle.
- rd_en_o and rd_addr_o are combinational from state and counters.
- rd_addr_o holds its last value when rd_en_o=0.

**Output buffer:**
- 2-entry FIFO. rd_data_i is written on the cycle after rd_en_o.
- m_data_o and m_valid_o are driven from the FIFO head.
- A push and a pop in the same cycle are both honoured.
- The FIFO never overflows; any overflow is a design error, and the bench asserts on it.

**Last-word flag:** m_last_o=1 exactly when the head word is index len-1. A sent counter tracks the index.

**Status outputs:**
- busy_o=1 in READ, DRAIN and DONE.
- start_i outside IDLE is ignored, including in DONE.

**Reset:**
- Reset at any time returns the block to IDLE, flushes the FIFO and clears the counters.
- No done_o is produced for an aborted stream.

## Timing
**Reset values:** rd_en_o=0, rd_addr_o=0, m_data_o=0, m_valid_o=0, m_last_o=0, busy_o=0, done_o=0.

**Start to first word:**
- Start sampled at edge E0.
- State is READ and busy_o=1 in cycle E0+1; rd_en_o=1 with address 0 in the same cycle.
- Data returns in E0+2 and is pushed at the end of E0+2.
- m_valid_o=1 from cycle E0+3.

**Throughput:** with m_ready_i held high, one word per cycle, consecutive addresses. A len-word stream occupies m_valid_o in cycles E0+3 … E0+2+len.

**Done timing:**
- done_o=1 in the cycle after the last handshake; busy_o falls one cycle later.
- For len=0: DONE in E0+1 with done_o=1, no reads and no valid.

**Backpressure:**
- m_data_o and m_last_o are stable while m_valid_o=1 and m_ready_i=0.
- m_valid_o never deasserts without a handshake.

**Back-to-back streams:** the earliest new start is accepted in the cycle after DONE, i.e. in IDLE.

## Test plan
- len=5, Z[0..4]=0x11,0x22,0x33,0x44,0x55, ready=1 → rd_en_o at cycles 1–5 with addresses 0–4; valid at cycles 3–7 carrying 0x11..0x55; last with 0x55 at cycle 7; done_o at cycle 8; busy_o low at cycle 9.
- len=39, m_ready_i random at 50% → 39 words in order, each exactly once; data stable while stalled; FIFO occupancy ≤2; rd_en_o never issued with 2 words in flight or buffered.
- len=0 → done_o at cycle 1; rd_en_o, m_valid_o and m_last_o never asserted.
- len=100, ADDR_W=6 → clamped to 64 words; final address 63; m_last_o with Z[63]; no address wrap.
- start_i pulsed again during READ, and again during DONE → ignored; exactly one stream and one done_o.
- rst low during the word-3 stall of a len=10 stream → all outputs return to reset values immediately; no done_o; a new start then streams Z[0..] correctly.

Source files
------------

// File: rtl/conv_z_streamer.sv
// rtl/conv_z_streamer.sv - Z result memory readout streamer with 2-entry output buffer
module conv_z_streamer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_rd_cnt;
    logic [ADDR_W:0]     r_sent;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic                r_inflight;
    logic [DATA_W-1:0]   r_mem [0:1];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;

    logic                w_start;
    logic [ADDR_W:0]     w_len_clamp;
    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_occ;

    // A start is only honoured in IDLE; longer requests are clamped to the memory depth
    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_len_clamp = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign w_pop       = m_valid_o & m_ready_i;
    assign w_push      = r_inflight;
    // Words that will occupy the buffer after this cycle if no new read were issued
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign m_valid_o   = (r_count != 2'd0);
    assign m_data_o    = m_valid_o ? r_mem[r_rptr] : '0;
    assign m_last_o    = m_valid_o && (r_sent == (r_len - 1'b1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = (w_len_clamp == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_en_o && (r_rd_cnt == (r_len - 1'b1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && m_last_o) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs: reads are throttled so the buffer plus the in-flight read never exceeds two
    always_comb begin
        rd_en_o   = (r_state == S_READ) && (w_occ < 3'd2);
        rd_addr_o = rd_en_o ? r_rd_cnt[ADDR_W-1:0] : r_addr_hold;
        busy_o    = (r_state != S_IDLE);
        done_o    = (r_state == S_DONE);
    end

    // Stream length, read-address and sent-word counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_sent      <= '0;
            r_addr_hold <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= rd_en_o;
            if (w_start) begin
                r_len    <= w_len_clamp;
                r_rd_cnt <= '0;
                r_sent   <= '0;
            end else begin
                if (rd_en_o) begin
                    r_rd_cnt    <= r_rd_cnt + 1'b1;
                    r_addr_hold <= rd_addr_o;
                end
                if (w_pop) begin
                    r_sent <= r_sent + 1'b1;
                end
            end
        end
    end

    // Two-entry output buffer; read data lands here one cycle after its read enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= rd_data_i;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_conv_z_streamer.sv
// tb/tb_conv_z_streamer.sv - self-checking bench for conv_z_streamer
module tb_conv_z_streamer;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [6:0]  len_i;
    logic        rd_en_o;
    logic [5:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_last_o;
    logic        busy_o;
    logic        done_o;

    logic [31:0] zmem [0:63];

    int total;
    int bad;

    typedef struct {
        logic        ready;
        logic        rd_en;
        logic [5:0]  addr;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vt [0:8];

    conv_z_streamer #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .len_i     (len_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_last_o  (m_last_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Z memory model with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= zmem[rd_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en_o), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
        chk({tag, "_data"}, m_data_o, 32'd0);
        chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
        chk({tag, "_last"}, 32'(m_last_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
    endtask

    task automatic run_stream(input int len, input bit rnd, input int ign_a, input int ign_b);
        int eff, idx, naddr, occ, done_cyc, last_hs, ndone;
        bit infl, pop, stalled;
        logic [31:0] pdata;
        logic plast;
        eff = (len > 64) ? 64 : len;
        idx = 0; naddr = 0; occ = 0; infl = 0; stalled = 0;
        done_cyc = -1; last_hs = -1; ndone = 0;
        pdata = '0; plast = 1'b0;
        @(negedge clk);
        start_i = 1'b1; len_i = 7'(len); m_ready_i = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            start_i   = (c == ign_a) || (c == ign_b);
            len_i     = 7'd3;
            m_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            pop = m_valid_o && m_ready_i;
            chk("valid", 32'(m_valid_o), 32'(occ != 0));
            if (stalled) begin
                chk("stall_data", m_data_o, pdata);
                chk("stall_last", 32'(m_last_o), 32'(plast));
            end
            chk("last", 32'(m_last_o), 32'((occ != 0) && (idx == eff - 1)));
            if (pop) begin
                chk("data", m_data_o, zmem[idx % 64]);
                idx++;
                last_hs = c;
            end
            if (rd_en_o) begin
                chk("rd_rule", 32'((occ + int'(infl) - int'(pop)) < 2), 32'd1);
                chk("addr", 32'(rd_addr_o), 32'(naddr));
                naddr++;
            end
            chk("busy", 32'(busy_o), 32'(done_cyc < 0));
            if (done_o) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    chk("done_after_last", 32'(c), 32'((eff == 0) ? 1 : last_hs + 1));
                end
            end
            occ = occ + int'(infl) - int'(pop);
            chk("occ_max", 32'(occ <= 2), 32'd1);
            infl    = rd_en_o;
            stalled = m_valid_o && !m_ready_i;
            pdata   = m_data_o;
            plast   = m_last_o;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start_i = 1'b0;
        chk("timeout", 32'(done_cyc >= 0), 32'd1);
        chk("ndone", 32'(ndone), 32'd1);
        chk("nwords", 32'(idx), 32'(eff));
        chk("nreads", 32'(naddr), 32'(eff));
        if (!rnd) chk("done_lat", 32'(done_cyc), 32'((eff == 0) ? 1 : eff + 3));
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 64; i++) begin
            zmem[i] = (i < 5) ? 32'(17 * (i + 1)) : (32'hC0DE_0000 | 32'(i));
        end
        // len=5, ready held high: cycles 1..9 after start
        vt[0] = '{1'b1, 1'b1, 6'd0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1'b1, 1'b1, 6'd1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b1, 6'd2, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 6'd3, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b1, 1'b1, 6'd4, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 6'd4, 1'b1, 32'h44, 1'b0, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b0, 6'd4, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1};
        vt[7] = '{1'b1, 1'b0, 6'd4, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1};
        vt[8] = '{1'b1, 1'b0, 6'd4, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};

        rst = 1'b0; start_i = 1'b0; len_i = '0; m_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        start_i = 1'b1; len_i = 7'd5; m_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start_i   = 1'b0;
            m_ready_i = vt[i].ready;
            #1;
            chk($sformatf("t5_rd_en_c%0d", i + 1), 32'(rd_en_o), 32'(vt[i].rd_en));
            chk($sformatf("t5_addr_c%0d", i + 1), 32'(rd_addr_o), 32'(vt[i].addr));
            chk($sformatf("t5_valid_c%0d", i + 1), 32'(m_valid_o), 32'(vt[i].valid));
            if (vt[i].valid) chk($sformatf("t5_data_c%0d", i + 1), m_data_o, vt[i].data);
            chk($sformatf("t5_last_c%0d", i + 1), 32'(m_last_o), 32'(vt[i].last));
            chk($sformatf("t5_done_c%0d", i + 1), 32'(done_o), 32'(vt[i].done));
            chk($sformatf("t5_busy_c%0d", i + 1), 32'(busy_o), 32'(vt[i].busy));
        end

        run_stream(39, 1'b1, -1, -1);
        run_stream(0, 1'b0, -1, -1);
        run_stream(100, 1'b0, -1, -1);
        run_stream(8, 1'b0, 2, 11);
        run_stream(17, 1'b1, -1, -1);

        // Reset while word 3 of a len=10 stream is stalled
        @(negedge clk);
        start_i = 1'b1; len_i = 7'd10; m_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        m_ready_i = 1'b0;
        #1;
        chk("abort_valid", 32'(m_valid_o), 32'd1);
        chk("abort_w3", m_data_o, zmem[3]);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        #1 chk("abort_done_hold", 32'(done_o), 32'd0);
        rst = 1'b1; m_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("abort_no_done", 32'(done_o), 32'd0);
        run_stream(10, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
